// File: rtl/csa_pkg.sv
// ----------------------------------------------------------------------------
// csa_pkg
//   Shared types and width helpers for the carry-save accumulator.
//   - csa_state_e   : accumulator sequencing states.
//   - guard_bits    : extra high-order bits that hold MAX_TERMS operands
//                     without losing the signed overflow information.
//   - resolve_width : width of the internal registers, which is also the
//                     number of bit-serial resolve cycles.
//   Optional feature macro: CSA_ACCUM_OVF_EN (adds guard bits to the
//   internal datapath and enables overflow detection).
// ----------------------------------------------------------------------------
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUTPUT  = 2'd2
    } csa_state_e;

    function automatic int guard_bits(input int max_terms);
        return $clog2(max_terms);
    endfunction

    function automatic int resolve_width(input int width, input int max_terms);
`ifdef CSA_ACCUM_OVF_EN
        return width + guard_bits(max_terms);
`else
        // Without guard bits the extra term is unused; the sum only wraps.
        return width + 0 * max_terms;
`endif
    endfunction

endpackage

// File: rtl/csa_accum_seq_row.sv
// ----------------------------------------------------------------------------
// full_adder / csa_row
//   full_adder : single-bit full adder.
//     a, b, cin  - input bits
//     sum, cout  - sum and carry-out bits
//   csa_row    : one 3:2 compressor row built from N full adders.
//     a, b, c [N-1:0] - three operand vectors
//     sum     [N-1:0] - bitwise sum (a ^ b ^ c)
//     carry   [N-1:0] - bitwise majority, NOT shifted; the caller applies
//                       the one-place left shift.
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module csa_row #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (carry[i])
        );
    end

endmodule

// File: rtl/csa_accum_seq.sv
// ----------------------------------------------------------------------------
// csa_accum_seq
//   Sequenced multi-operand accumulator. Operands arriving on the input
//   handshake are folded into carry-save registers (one 3:2 row per beat).
//   After the last operand the redundant pair is resolved LSB-first through
//   one shared full adder, and the binary result is offered on the output
//   handshake.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. in_ready is high only in ACCUM; out_valid is high only in
//   OUTPUT, and out_data/out_ovf hold steady until out_ready is seen high.
//
//   Ports:
//     clk, rst_n            - clock, asynchronous active-low reset
//     in_valid/in_ready     - operand handshake
//     in_data [WIDTH-1:0]   - operand (unsigned or two's complement)
//     in_last               - marks final operand of a sum
//     out_valid/out_ready   - result handshake
//     out_data [WIDTH-1:0]  - resolved sum, modulo 2^WIDTH
//     out_ovf               - signed overflow (0 unless CSA_ACCUM_OVF_EN)
//     busy                  - high while resolving or presenting a result
//
//   Optional feature macro: CSA_ACCUM_OVF_EN.
// ----------------------------------------------------------------------------
module csa_accum_seq
    import csa_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_TERMS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int RW = resolve_width(WIDTH, MAX_TERMS);
    localparam int CW = $clog2(MAX_TERMS + 1);
    localparam int BW = $clog2(RW + 1);

    csa_state_e    state_q, state_d;
    logic [RW-1:0] s_q, s_d;
    logic [RW-1:0] c_q, c_d;
    logic [RW-1:0] res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sc_q, sc_d;

    logic [RW-1:0] d_ext;
    logic [RW-1:0] row_sum;
    logic [RW-1:0] row_carry;
    logic          fa_sum;
    logic          fa_cout;

`ifdef CSA_ACCUM_OVF_EN
    localparam int G = guard_bits(MAX_TERMS);
    // Sign-extend so two's complement operands accumulate correctly in
    // the guard bits.
    assign d_ext = {{G{in_data[WIDTH-1]}}, in_data};
`else
    assign d_ext = in_data;
`endif

    csa_row #(
        .N (RW)
    ) u_row (
        .a     (s_q),
        .b     (c_q),
        .c     (d_ext),
        .sum   (row_sum),
        .carry (row_carry)
    );

    // Shared bit-serial resolver: LSBs of sum and carry plus the running carry.
    full_adder u_fa (
        .a    (s_q[0]),
        .b    (c_q[0]),
        .cin  (sc_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sc_d    = sc_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    s_d   = row_sum;
                    // Carry weight is one bit higher; the MSB carry is dropped
                    // (modulo arithmetic).
                    c_d   = {row_carry[RW-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (in_last || (cnt_q == CW'(MAX_TERMS - 1))) begin
                        state_d = RESOLVE;
                        bit_d   = '0;
                        sc_d    = 1'b0;
                    end
                end
            end
            RESOLVE: begin
                // Result fills from the MSB end, so after RW shifts bit 0 of
                // the sum sits at res_q[0].
                res_d = {fa_sum, res_q[RW-1:1]};
                s_d   = s_q >> 1;
                c_d   = c_q >> 1;
                sc_d  = fa_cout;
                bit_d = bit_q + BW'(1);
                if (bit_q == BW'(RW - 1)) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            sc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sc_q    <= sc_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q == RESOLVE) || (state_q == OUTPUT);
    assign out_data  = res_q[WIDTH-1:0];

`ifdef CSA_ACCUM_OVF_EN
    // Signed overflow: the guard bits and the result sign bit disagree.
    logic [G:0] top_bits;
    assign top_bits = res_q[RW-1:WIDTH-1];
    assign out_ovf  = out_valid && !((&top_bits) || (~|top_bits));
`else
    assign out_ovf  = 1'b0;
`endif

endmodule
